// File: rtl/pipe_hazard_scoreboard_if.sv
// Issue/hazard bus between decode and the hazard scoreboard.
// The master modport is decode's side and the slave modport is the scoreboard's side.
interface pipe_hazard_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  issue_valid;
   logic [REG_ADDR_W-1:0] issue_rs;
   logic [REG_ADDR_W-1:0] issue_rt;
   logic                  issue_use_rs;
   logic                  issue_use_rt;
   logic [REG_ADDR_W-1:0] issue_rd;
   logic                  issue_wr;
   logic                  issue_load;
   logic                  flush;
   logic                  stall_o;
   logic [2:0]            fwd_rs_sel;
   logic [2:0]            fwd_rt_sel;
   logic [2:0]            inflight_o;
   logic [CNT_W-1:0]      stall_cnt_o;

   modport master (
      output issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
             issue_rd, issue_wr, issue_load, flush,
      input  stall_o, fwd_rs_sel, fwd_rt_sel, inflight_o, stall_cnt_o
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rt, issue_use_rs, issue_use_rt,
             issue_rd, issue_wr, issue_load, flush,
      output stall_o, fwd_rs_sel, fwd_rt_sel, inflight_o, stall_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Hazard/forwarding scoreboard. It tracks destination tags for DEPTH post-decode stages.
// It produces the load-use stall, the forward selects and the flush kill for the decode instruction.
module pipe_hazard_scoreboard #(
   parameter int REG_ADDR_W  = 5,
   parameter int DEPTH       = 3,
   parameter int LOAD_AVAIL  = 2,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipe_hazard_scoreboard_if.slave hz
);
   // Stage k of the pipeline lives at index k, so index 1 is execute.
   logic [DEPTH:1]                 vld_pipe_q, vld_pipe_d;
   logic [DEPTH:1]                 wr_q, wr_d;
   logic [DEPTH:1]                 ld_q, ld_d;
   logic [DEPTH:1][REG_ADDR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;

   logic [DEPTH:1] ready;
   logic [DEPTH:1] rs_hit, rt_hit;
   logic [2:0]     rs_sel, rt_sel, inflight;
   logic           rs_blk, rt_blk, stall, fire;

   always_comb begin
      ready  = '0;
      rs_hit = '0;
      rt_hit = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         ready[k]  = vld_pipe_q[k] && wr_q[k] && (!ld_q[k] || k >= LOAD_AVAIL);
         rs_hit[k] = hz.issue_use_rs && (hz.issue_rs != '0) && vld_pipe_q[k] &&
                     wr_q[k] && (rd_q[k] == hz.issue_rs);
         rt_hit[k] = hz.issue_use_rt && (hz.issue_rt != '0) && vld_pipe_q[k] &&
                     wr_q[k] && (rd_q[k] == hz.issue_rt);
      end
   end

   // Walk the stages from oldest to youngest, so the youngest producer ends up selected.
   always_comb begin
      rs_sel = '0;
      rt_sel = '0;
      rs_blk = 1'b0;
      rt_blk = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (rs_hit[k]) begin
            rs_sel = ready[k] ? 3'(k) : 3'd0;
            rs_blk = !ready[k];
         end
         if (rt_hit[k]) begin
            rt_sel = ready[k] ? 3'(k) : 3'd0;
            rt_blk = !ready[k];
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         if (vld_pipe_q[k] && wr_q[k]) inflight = inflight + 3'd1;
      end
   end

   assign stall = hz.issue_valid && (rs_blk || rt_blk) && !hz.flush;
   assign fire  = hz.issue_valid && !stall && !hz.flush;

   always_comb begin
      vld_pipe_d = '0;
      wr_d       = '0;
      ld_d       = '0;
      rd_d       = '0;
      vld_pipe_d[1] = fire;
      wr_d[1]       = hz.issue_wr;
      ld_d[1]       = hz.issue_load;
      rd_d[1]       = hz.issue_rd;
      for (int k = 2; k <= DEPTH; k++) begin
         vld_pipe_d[k] = vld_pipe_q[k-1];
         wr_d[k]       = wr_q[k-1];
         ld_d[k]       = ld_q[k-1];
         rd_d[k]       = rd_q[k-1];
      end
      // Kill the younger wrong-path stages after the shift.
      if (hz.flush) begin
         for (int k = 1; k <= FLUSH_DEPTH; k++) vld_pipe_d[k] = 1'b0;
      end
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q  <= '0;
         wr_q        <= '0;
         ld_q        <= '0;
         rd_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         wr_q        <= wr_d;
         ld_q        <= ld_d;
         rd_q        <= rd_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall_o     = stall;
   assign hz.fwd_rs_sel  = hz.issue_valid ? rs_sel : 3'd0;
   assign hz.fwd_rt_sel  = hz.issue_valid ? rt_sel : 3'd0;
   assign hz.inflight_o  = inflight;
   assign hz.stall_cnt_o = stall_cnt_q;
endmodule
